// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, ALU op codes, funct3 values, NOP word
// and the program loader state type.
package cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PAD  = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/instr_encode.sv
// Combinational ALU request to RV32I word encoder with a validity flag
// for unsupported op codes.
module instr_encode
  import cpu_pkg::*;
(
  input  logic        is_imm,
  input  logic [2:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm12,
  output logic [31:0] word,
  output logic        valid
);

  logic [2:0] f3;

  always_comb begin
    f3    = F3_ADD;
    valid = 1'b1;
    unique case (1'b1)
      alu_op == ALU_ADD: f3 = F3_ADD;
      alu_op == ALU_XOR: f3 = F3_XOR;
      alu_op == ALU_OR:  f3 = F3_OR;
      alu_op == ALU_AND: f3 = F3_AND;
      default:           valid = 1'b0;
    endcase
  end

  assign word = is_imm
    ? {imm12, rs1, f3, rd, OPC_OP_IMM}
    : {7'b0, rs2, rs1, f3, rd, OPC_OP};

endmodule

// File: rtl/instr_loader.sv
// Sequential program loader writing encoded ALU instructions to imem.
// Define LOADER_NOP_PAD_EN to fill the rest of memory with NOPs on commit.
module instr_loader
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_is_imm,
  input  logic [2:0]    in_alu_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [11:0]   in_imm12,
  input  logic          commit,
  input  logic          clear,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  ld_state_t     state_q, state_d;
  logic [AW:0]   count_d;
  logic          we_d, err_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   wdata_d;
  logic [31:0]   enc_word;
  logic          enc_ok;
  logic          xfer;

  instr_encode u_enc (
    .is_imm (in_is_imm),
    .alu_op (in_alu_op),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm12  (in_imm12),
    .word   (enc_word),
    .valid  (enc_ok)
  );

  assign in_ready = rst_n && state_q == ST_LOAD
                 && count < FULL && !clear;
  assign xfer = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count;
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    if (clear) begin
      state_d = ST_LOAD;
      count_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer && enc_ok) begin
            we_d    = 1'b1;
            addr_d  = count[AW-1:0];
            wdata_d = enc_word;
            count_d = count + 1'b1;
          end
          err_d = xfer && !enc_ok;
          if (commit) begin
`ifdef LOADER_NOP_PAD_EN
            state_d = (count_d < FULL) ? ST_PAD : ST_DONE;
`else
            state_d = ST_DONE;
`endif
          end
        end
`ifdef LOADER_NOP_PAD_EN
        ST_PAD: begin
          we_d    = 1'b1;
          addr_d  = count[AW-1:0];
          wdata_d = NOP_WORD;
          count_d = count + 1'b1;
          if (count_d == FULL) state_d = ST_DONE;
        end
`endif
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      count      <= count_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      err        <= err_d;
    end
  end

  // done waits out the final write beat still on the bus
  assign done = state_q == ST_DONE && !imem_we;

`ifdef LOADER_NOP_PAD_EN
  assign busy = state_q == ST_PAD;
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (DEPTH=8) against a cycle
// reference model and a shadow image of instruction memory.
module tb_instr_loader;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef LOADER_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_is_imm = 1'b0;
  logic [2:0]    in_alu_op = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [11:0]   in_imm12 = '0;
  logic          commit = 1'b0;
  logic          clear = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          busy, done, err;

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_imm  (in_is_imm),
    .in_alu_op  (in_alu_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm12   (in_imm12),
    .commit     (commit),
    .clear      (clear),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum {M_LOAD, M_PAD, M_DONE} mphase_t;
  mphase_t     m_phase = M_LOAD;
  int          m_cnt = 0;
  bit          m_we = 1'b0;
  bit          m_err = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_wdata = '0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] dut_mem [DEPTH];
  int          beats = 0;
  int          busy_cycles = 0;

  logic [2:0] vops [4] = '{3'b001, 3'b100, 3'b110, 3'b111};
  logic [2:0] bops [4] = '{3'b000, 3'b010, 3'b011, 3'b101};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(bit imm, logic [2:0] op,
      logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [11:0] i12);
    logic [31:0] f3;
    f3 = (op == 3'b001) ? 32'd0 : {29'd0, op};
    if (imm)
      return ({20'd0, i12} << 20) | ({27'd0, rs1} << 15)
           | (f3 << 12) | ({27'd0, rd} << 7) | 32'h13;
    return ({27'd0, rs2} << 20) | ({27'd0, rs1} << 15)
         | (f3 << 12) | ({27'd0, rd} << 7) | 32'h33;
  endfunction

  function automatic bit exp_ready();
    return m_phase == M_LOAD && m_cnt < DEPTH && !clear;
  endfunction

  task automatic model_reset();
    m_phase = M_LOAD;
    m_cnt   = 0;
    m_we    = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    bit rdy;
    rdy   = exp_ready();
    m_we  = 1'b0;
    m_err = 1'b0;
    if (clear) begin
      m_phase = M_LOAD;
      m_cnt   = 0;
    end else if (m_phase == M_LOAD) begin
      if (in_valid && rdy) begin
        if (in_alu_op inside {3'b001, 3'b100, 3'b110, 3'b111}) begin
          m_we    = 1'b1;
          m_addr  = m_cnt;
          m_wdata = ref_enc(in_is_imm, in_alu_op, in_rd, in_rs1,
                            in_rs2, in_imm12);
          ref_mem[m_cnt] = m_wdata;
          m_cnt++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (commit)
        m_phase = (PAD_EN && m_cnt < DEPTH) ? M_PAD : M_DONE;
    end else if (m_phase == M_PAD) begin
      m_we    = 1'b1;
      m_addr  = m_cnt;
      m_wdata = 32'h0000_0013;
      ref_mem[m_cnt] = m_wdata;
      m_cnt++;
      if (m_cnt == DEPTH) m_phase = M_DONE;
    end
  endtask

  task automatic chk_outputs();
    chk("imem_we", imem_we, m_we);
    if (m_we) begin
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, m_wdata);
    end
    chk("count", count, m_cnt);
    chk("err", err, m_err);
    chk("busy", busy, PAD_EN && m_phase == M_PAD);
    chk("done", done, m_phase == M_DONE && !m_we);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic step(bit v, bit imm, logic [2:0] op, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [11:0] i12,
      bit cm, bit cl);
    @(negedge clk);
    in_valid  = v;
    in_is_imm = imm;
    in_alu_op = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm12  = i12;
    commit    = cm;
    clear     = cl;
    #1;
    chk("in_ready", in_ready, exp_ready());
    model_step();
    @(posedge clk);
    #1;
    chk_outputs();
    if (imem_we === 1'b1) begin
      dut_mem[imem_addr] = imem_wdata;
      beats++;
    end
    if (busy === 1'b1) busy_cycles++;
  endtask

  task automatic idle();
    step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic req(bit imm, logic [2:0] op, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [11:0] i12);
    step(1, imm, op, rd, rs1, rs2, i12, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 0, 3'b000, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rand_req(bit cm, bit cl);
    logic [2:0] op;
    op = ($urandom_range(3) != 0) ? vops[$urandom_range(3)]
                                  : bops[$urandom_range(3)];
    step(1'($urandom_range(1)), 1'($urandom_range(1)), op,
         5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
         cm, cl);
  endtask

  task automatic chk_mem(string tag);
    for (int i = 0; i < DEPTH; i++)
      chk(tag, dut_mem[i], ref_mem[i]);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      dut_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    req(1, 3'b001, 5'd1, 5'd0, 5'd0, 12'd5);
    chk("addi_word", imem_wdata, 32'h0050_0093);
    chk("addi_addr", imem_addr, 0);
    chk("addi_count", count, 1);

    do_clear();
    req(0, 3'b100, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("xor_word", imem_wdata, 32'h0020_C1B3);
    chk("xor_addr", imem_addr, 0);
    req(0, 3'b111, 5'd4, 5'd3, 5'd3, 12'd0);
    chk("and_word", imem_wdata, 32'h0031_F233);
    chk("and_addr", imem_addr, 1);

    req(1, 3'b010, 5'd7, 5'd7, 5'd7, 12'd9);
    chk("inv_err", err, 1);
    chk("inv_we", imem_we, 0);
    chk("inv_count", count, 2);
    idle();
    chk("inv_err_clr", err, 0);

    do_clear();
    beats = 0;
    for (int i = 0; i < 10; i++)
      step(1, 1, vops[i % 4], 5'(i), 5'(i + 1), 0, 12'(i * 3), 0, 0);
    chk("fill_beats", beats, 8);
    chk("fill_count", count, 8);
    chk("fill_ready", in_ready, 0);
    step(0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    chk("fill_done", done, 1);
    chk_mem("fill_mem");

    do_clear();
    for (int i = 0; i < 3; i++)
      req(0, vops[i], 5'(i + 8), 5'(i), 5'(i + 2), 0);
    beats = 0;
    busy_cycles = 0;
    step(0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    repeat (7) idle();
    chk("pad_beats", beats, PAD_EN ? 5 : 0);
    chk("pad_busy", busy_cycles, PAD_EN ? 5 : 0);
    chk("pad_done", done, 1);
    chk_mem("pad_mem");

    do_clear();
    for (int i = 0; i < 3; i++)
      req(1, 3'b110, 5'(i), 5'(i), 0, 12'hfff);
    step(0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    req(0, 3'b001, 5'd5, 5'd6, 5'd7, 0);
    req(1, 3'b100, 5'd9, 5'd9, 0, 12'h800);
    step(1, 1, 3'b001, 5'd1, 5'd1, 0, 12'd1, 1, 1);
    chk("cc_count", count, 0);
    chk("cc_done", done, 0);
    chk("cc_we", imem_we, 0);
    idle();
    chk("cc_ready", in_ready, 1);

    for (int b = 0; b < 6; b++) begin
      do_clear();
      for (int i = 0; i < 14; i++)
        rand_req($urandom_range(11) == 0, $urandom_range(29) == 0);
      step(1, 0, 3'b111, 5'd2, 5'd3, 5'd4, 0, 1, 0);
      repeat (10) idle();
      chk_mem("rand_mem");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
